// File: rtl/unpad_pkg.sv
// Purpose: shared types and helpers for the 10* padding stripper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: nbw() sizes the valid-bit count field; unpad_state_t tracks
// whether the stream is inside a multi-block message.
package unpad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } unpad_state_t;

  // Width needed to hold a bit count in the range 0..iwidth inclusive.
  function automatic int nbw(input int iwidth);
    return $clog2(iwidth + 1);
  endfunction

endpackage

// File: rtl/unpad_msb_find.sv
// Purpose: combinational highest-set-bit priority encoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake, output follows input.
//
// Ports:
//   in_i    [IWIDTH-1:0]  word to search
//   idx_o   [NBW-1:0]     index of the highest set bit (0 when in_i is zero)
//   found_o               at least one bit of in_i is set
module unpad_msb_find
  import unpad_pkg::*;
#(
  parameter  int IWIDTH = 64,
  localparam int NBW    = nbw(IWIDTH)
) (
  input  logic [IWIDTH-1:0] in_i,
  output logic [NBW-1:0]    idx_o,
  output logic              found_o
);

  // Ascending scan: the last set bit seen wins, giving the highest index.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < IWIDTH; i++) begin
      if (in_i[i]) begin
        idx_o = NBW'(i);
      end
    end
  end

  assign found_o = |in_i;

endmodule

// File: rtl/unpad_stream.sv
// Purpose: strip 10* padding from the final block of each message; body blocks pass through.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output holds all out_* stable.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          input handshake
//   in_data [IWIDTH-1:0]       padded block
//   in_last                    block is the final block of a message
//   out_valid/out_ready        output handshake
//   out_data [IWIDTH-1:0]      block with the marker and everything above it cleared
//   out_nbits [NBW-1:0]        valid data bits in out_data
//   out_last                   final beat of a message
//   out_err                    final block carried no padding marker
//   out_msgbits [LENW-1:0]     total message bits on the out_last beat
//                              (present only with UNPAD_LENCNT_EN defined)
// Build option: define UNPAD_LENCNT_EN to add the message-length counter,
// the IDLE/BODY tracker, the LENW parameter and the out_msgbits port.
module unpad_stream
  import unpad_pkg::*;
#(
  parameter  int IWIDTH = 64,
`ifdef UNPAD_LENCNT_EN
  parameter  int LENW   = 32,
`endif
  localparam int NBW    = nbw(IWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IWIDTH-1:0] out_data,
  output logic [NBW-1:0]    out_nbits,
  output logic              out_last,
`ifdef UNPAD_LENCNT_EN
  output logic [LENW-1:0]   out_msgbits,
`endif
  output logic              out_err
);

  logic [NBW-1:0]    msb_idx;
  logic              msb_found;
  logic              in_xfer;

  logic              valid_q, valid_d;
  logic [IWIDTH-1:0] data_q, data_d;
  logic [NBW-1:0]    nbits_q, nbits_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  unpad_msb_find #(.IWIDTH(IWIDTH)) u_msb_find (
    .in_i    (in_data),
    .idx_o   (msb_idx),
    .found_o (msb_found)
  );

  assign in_ready = !valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    last_d  = in_last;
    data_d  = in_data;
    nbits_d = NBW'(IWIDTH);
    err_d   = 1'b0;
    if (in_last) begin
      // Keep only bits below the marker. An all-zero block yields idx 0,
      // which also clears everything and reports zero data bits.
      data_d  = in_data & ~({IWIDTH{1'b1}} << msb_idx);
      nbits_d = msb_idx;
      err_d   = !msb_found;
    end
  end

  // A new beat loads whenever the slot is free or draining this cycle;
  // otherwise the slot empties once the sink takes it.
  always_comb begin
    valid_d = valid_q;
    if (in_xfer) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      nbits_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (in_xfer) begin
        data_q  <= data_d;
        nbits_q <= nbits_d;
        last_q  <= last_d;
        err_q   <= err_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_nbits = nbits_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

`ifdef UNPAD_LENCNT_EN
  unpad_state_t    state_q;
  logic [LENW-1:0] cnt_q;
  logic [LENW-1:0] msgbits_q;
  logic [LENW-1:0] sum_d;

  // The first block of a message starts the total from zero.
  assign sum_d = ((state_q == IDLE) ? '0 : cnt_q) + LENW'(nbits_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      msgbits_q <= '0;
    end else if (in_xfer) begin
      if (in_last) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        msgbits_q <= sum_d;
      end else begin
        state_q   <= BODY;
        cnt_q     <= sum_d;
        msgbits_q <= '0;
      end
    end
  end

  assign out_msgbits = msgbits_q;
`endif

endmodule

// File: tb/tb_unpad_stream.sv
// Purpose: self-checking bench for unpad_stream with directed and random traffic.
// Latency: expects outputs one cycle after each input transfer.
// Backpressure: drives random out_ready stalls and checks held outputs stay stable.
module tb_unpad_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [6:0]  out_nbits;
  logic        out_last;
  logic        out_err;
`ifdef UNPAD_LENCNT_EN
  logic [31:0] out_msgbits;
`endif

  unpad_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .out_last  (out_last),
`ifdef UNPAD_LENCNT_EN
    .out_msgbits (out_msgbits),
`endif
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  nbits;
    logic        last;
    logic        err;
    logic [31:0] msgbits;
  } exp_t;

  typedef logic [105:0] pack_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        q[$];
  logic [31:0] acc = 0;

  // Snapshot of every DUT output as one vector: {valid,last,err,nbits,data,msgbits}.
  function automatic pack_t got_pack();
    logic [31:0] m;
`ifdef UNPAD_LENCNT_EN
    m = out_msgbits;
`else
    m = 32'h0;
`endif
    return {out_valid, out_last, out_err, out_nbits, out_data, m};
  endfunction

  function automatic pack_t exp_pack(input exp_t e);
    logic [31:0] m;
`ifdef UNPAD_LENCNT_EN
    m = e.msgbits;
`else
    m = 32'h0;
`endif
    return {1'b1, e.last, e.err, e.nbits, e.data, m};
  endfunction

  function automatic exp_t mk(input logic [63:0] d, input int nb, input logic l,
                              input logic er, input int mb);
    exp_t e;
    e.data = d; e.nbits = 7'(nb); e.last = l; e.err = er; e.msgbits = 32'(mb);
    return e;
  endfunction

  // Reference: the marker is the largest power of two not exceeding the block,
  // so the data is the block minus that power and the bit count is its exponent.
  function automatic exp_t model(input logic [63:0] d, input logic last);
    exp_t        e;
    logic [64:0] p;
    int          k;
    e.last = last; e.err = 1'b0; e.msgbits = 0;
    if (!last) begin
      e.data = d; e.nbits = 7'd64;
    end else if (d == 64'h0) begin
      e.data = 64'h0; e.nbits = 7'd0; e.err = 1'b1;
    end else begin
      k = 0; p = 65'd1;
      while ((p << 1) <= {1'b0, d}) begin
        p = p << 1;
        k++;
      end
      e.data = d - p[63:0]; e.nbits = 7'(k);
    end
    return e;
  endfunction

  task automatic model_push(input logic [63:0] d, input logic last);
    exp_t e;
    e = model(d, last);
    if (last) begin
      e.msgbits = acc + 32'(e.nbits);
      acc = 0;
    end else begin
      acc = acc + 32'(e.nbits);
    end
    q.push_back(e);
  endtask

  function automatic logic [63:0] rand_final();
    logic [63:0] one, r;
    int          kind, k;
    one  = 64'h1;
    r    = {$urandom, $urandom};
    kind = $urandom_range(0, 9);
    if (kind == 0) return 64'h0;
    if (kind == 1) return 64'h1;
    k = $urandom_range(0, 63);
    return (r & ((one << k) - 64'h1)) | (one << k);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (got_pack() !== 106'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", got_pack(), 106'h0);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [63:0] din[4];
    exp_t        ex[4];
    din[0] = 64'h8000_0000_DEAD_BEEF; ex[0] = mk(64'hDEAD_BEEF, 63, 1'b1, 1'b0, 63);
    din[1] = 64'h0000_0000_0000_01AB; ex[1] = mk(64'hAB, 8, 1'b1, 1'b0, 8);
    din[2] = 64'h1;                   ex[2] = mk(64'h0, 0, 1'b1, 1'b0, 0);
    din[3] = 64'h0;                   ex[3] = mk(64'h0, 0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = din[i]; in_last = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (got_pack() !== exp_pack(ex[i])) begin
        n_fail++; $display("FAIL final_vector%0d: got %h want %h", i, got_pack(), exp_pack(ex[i]));
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL vector_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_lencnt();
    logic [63:0] din[4];
    exp_t        ex[4];
    din[0] = {$urandom, $urandom}; ex[0] = mk(din[0], 64, 1'b0, 1'b0, 0);
    din[1] = {$urandom, $urandom}; ex[1] = mk(din[1], 64, 1'b0, 1'b0, 0);
    din[2] = 64'h80;               ex[2] = mk(64'h0, 7, 1'b1, 1'b0, 135);
    din[3] = 64'h80;               ex[3] = mk(64'h0, 7, 1'b1, 1'b0, 7);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (i < 4);
      if (i < 4) begin
        in_data = din[i]; in_last = (i >= 2);
      end
      #1;
      if (i > 0) begin
        n_checks++;
        if (got_pack() !== exp_pack(ex[i-1])) begin
          n_fail++; $display("FAIL lencnt_beat%0d: got %h want %h", i-1, got_pack(), exp_pack(ex[i-1]));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] b[4];
    exp_t        e;
    for (int i = 0; i < 3; i++) b[i] = {$urandom, $urandom};
    b[3] = ({$urandom, $urandom} & 64'h0000_00FF_FFFF_FFFF) | 64'h0000_0100_0000_0000;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = b[0]; in_last = 1'b0;
    #1;
    model_push(b[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_data = b[1];
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready);
      end
      n_checks++;
      if (got_pack() !== exp_pack(q[0])) begin
        n_fail++; $display("FAIL bp_hold_c%0d: got %h want %h", c, got_pack(), exp_pack(q[0]));
      end
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (j < 3);
      if (j < 3) begin
        in_data = b[j+1]; in_last = (j == 2);
      end
      #1;
      e = q.pop_front();
      n_checks++;
      if (got_pack() !== exp_pack(e)) begin
        n_fail++; $display("FAIL bp_release_beat%0d: got %h want %h", j, got_pack(), exp_pack(e));
      end
      if (j < 3) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL bp_release_ready%0d: got %b want 1", j, in_ready);
        end
        model_push(b[j+1], j == 2);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_duplicate: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_held: out_valid got %b want 1", out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    acc = 0;
    #1;
    n_checks++;
    if (got_pack() !== 106'h0) begin
      n_fail++; $display("FAIL rstmid_cleared: got %h want %h", got_pack(), 106'h0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h8000_0000_DEAD_BEEF; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    e = mk(64'hDEAD_BEEF, 63, 1'b1, 1'b0, 63);
    n_checks++;
    if (got_pack() !== exp_pack(e)) begin
      n_fail++; $display("FAIL rstmid_next_msg: got %h want %h", got_pack(), exp_pack(e));
    end
  endtask

  task automatic test_random();
    logic [63:0] pend_d;
    logic        pend_last;
    int          body_left;
    logic        stalled;
    pack_t       prev;
    exp_t        e;
    body_left = $urandom_range(0, 3);
    pend_last = (body_left == 0);
    pend_d    = pend_last ? rand_final() : {$urandom, $urandom};
    stalled   = 1'b0;
    prev      = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (got_pack() !== prev) begin
          n_fail++; $display("FAIL rand_stall_stable c%0d: got %h want %h", cyc, got_pack(), prev);
        end
      end
      in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
      in_data   = pend_d;
      in_last   = pend_last;
      out_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
      #1;
      stalled = out_valid && !out_ready;
      prev    = got_pack();
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected_beat c%0d: got %h want none", cyc, got_pack());
        end else begin
          e = q.pop_front();
          if (got_pack() !== exp_pack(e)) begin
            n_fail++; $display("FAIL rand_beat c%0d: got %h want %h", cyc, got_pack(), exp_pack(e));
          end
        end
      end
      if (in_valid && in_ready) begin
        model_push(pend_d, pend_last);
        if (pend_last) body_left = $urandom_range(0, 3);
        else           body_left--;
        pend_last = (body_left == 0);
        pend_d    = pend_last ? rand_final() : {$urandom, $urandom};
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rand_lost_beats: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_lencnt();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
